// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/result bundle between controller and muldiv_unit
interface muldiv_unit_if #(
  parameter int WIDTH   = 8,
  parameter int REGBITS = 3
);
  logic               start;
  logic               op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [REGBITS-1:0] dest;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic               regwrite_o;
  logic [REGBITS-1:0] wa_o;
  logic [WIDTH-1:0]   wd_o;

  // controller side: issues requests, consumes results and writeback
  modport master (
    output start, op, a, b, dest,
    input  busy, done, hi, lo, regwrite_o, wa_o, wd_o
  );

  // unit side
  modport slave (
    input  start, op, a, b, dest,
    output busy, done, hi, lo, regwrite_o, wa_o, wd_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle unsigned shift-add multiply / restoring divide with HI/LO and writeback
module muldiv_unit #(
  parameter int WIDTH   = 8,
  parameter int REGBITS = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, WB} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic                 op_reg;
  logic [WIDTH-1:0]     a_reg;
  logic [WIDTH-1:0]     b_reg;
  logic [REGBITS-1:0]   dest_reg;
  // upper half: partial product / partial remainder; lower half: multiplier / dividend->quotient
  logic [2*WIDTH-1:0]   work;
  logic [2*WIDTH-1:0]   work_next;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_trial;
  logic [WIDTH:0]       div_diff;

  assign bus.busy = (state != IDLE);

  // one multiply or divide iteration on the shared work register
  always_comb begin
    mul_sum   = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, a_reg} : '0);
    div_trial = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
    div_diff  = div_trial - {1'b0, b_reg};
    work_next = '0;
    if (op_reg) begin
      if (div_diff[WIDTH])
        work_next = {div_trial[WIDTH-1:0], work[WIDTH-2:0], 1'b0};
      else
        work_next = {div_diff[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
    end else begin
      work_next = {mul_sum, work[WIDTH-1:1]};
    end
  end

  // control FSM with registered result and writeback outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      op_reg         <= 1'b0;
      a_reg          <= '0;
      b_reg          <= '0;
      dest_reg       <= '0;
      work           <= '0;
      bus.hi         <= '0;
      bus.lo         <= '0;
      bus.done       <= 1'b0;
      bus.regwrite_o <= 1'b0;
      bus.wa_o       <= '0;
      bus.wd_o       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_reg   <= bus.op;
            a_reg    <= bus.a;
            b_reg    <= bus.b;
            dest_reg <= bus.dest;
            cnt      <= CW'(WIDTH);
            work     <= bus.op ? {{WIDTH{1'b0}}, bus.a} : {{WIDTH{1'b0}}, bus.b};
            if (bus.op && (bus.b == '0)) begin
              // divide by zero skips the iterations and reports all-ones / dividend
              state          <= WB;
              bus.hi         <= bus.a;
              bus.lo         <= '1;
              bus.done       <= 1'b1;
              bus.regwrite_o <= (bus.dest != '0);
              bus.wa_o       <= bus.dest;
              bus.wd_o       <= '1;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          work <= work_next;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state          <= WB;
            bus.hi         <= work_next[2*WIDTH-1:WIDTH];
            bus.lo         <= work_next[WIDTH-1:0];
            bus.done       <= 1'b1;
            bus.regwrite_o <= (dest_reg != '0);
            bus.wa_o       <= dest_reg;
            bus.wd_o       <= work_next[WIDTH-1:0];
          end
        end
        WB: begin
          state          <= IDLE;
          bus.done       <= 1'b0;
          bus.regwrite_o <= 1'b0;
          bus.wa_o       <= '0;
          bus.wd_o       <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  muldiv_unit_if #(.WIDTH(8), .REGBITS(3)) bus ();

  muldiv_unit #(.WIDTH(8), .REGBITS(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // issue one op, scramble operands after the start edge, wait for done;
  // returns cycles from start edge to done and how many of those had busy high
  task automatic run_op(input logic o, input logic [7:0] av, input logic [7:0] bv,
                        input logic [2:0] d, output int lat, output int nbusy);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.a = av; bus.b = bv; bus.dest = d;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.a = 8'hA5; bus.b = 8'h5A; bus.dest = 3'd6;
    lat = 0; nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (bus.busy) nbusy++;
      if (bus.done) break;
    end
    if (!bus.done) check("done_timeout", 32'(bus.done), 32'd1);
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_idle_done"}, 32'(bus.done), 32'd0);
    check({tag, "_idle_rw"},   32'(bus.regwrite_o), 32'd0);
    check({tag, "_idle_wa"},   32'(bus.wa_o), 32'd0);
    check({tag, "_idle_wd"},   32'(bus.wd_o), 32'd0);
  endtask

  initial begin
    int lat, nbusy, ndone;
    n_tests = 0; n_fail = 0;
    reset_n = 1'b0;
    bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0; bus.dest = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_rw",   32'(bus.regwrite_o), 32'd0);
    check("rst_wa",   32'(bus.wa_o), 32'd0);
    check("rst_wd",   32'(bus.wd_o), 32'd0);
    check("rst_hi",   32'(bus.hi), 32'd0);
    check("rst_lo",   32'(bus.lo), 32'd0);
    reset_n = 1'b1;

    // 1: 13*11 = 143
    run_op(1'b0, 8'd13, 8'd11, 3'd3, lat, nbusy);
    check("mul1_lat",  32'(lat), 32'd9);
    check("mul1_busy", 32'(nbusy), 32'd9);
    check("mul1_rw",   32'(bus.regwrite_o), 32'd1);
    check("mul1_wa",   32'(bus.wa_o), 32'd3);
    check("mul1_wd",   32'(bus.wd_o), 32'h8F);
    check("mul1_hi",   32'(bus.hi), 32'h00);
    check("mul1_lo",   32'(bus.lo), 32'h8F);
    check_idle("mul1");
    check("mul1_hold_lo", 32'(bus.lo), 32'h8F);

    // 2: 200*200 = 40000 = 0x9C40
    run_op(1'b0, 8'd200, 8'd200, 3'd1, lat, nbusy);
    check("mul2_hi", 32'(bus.hi), 32'h9C);
    check("mul2_lo", 32'(bus.lo), 32'h40);
    check("mul2_wd", 32'(bus.wd_o), 32'h40);
    check_idle("mul2");

    // 3: 100/7 = 14 r 2, then 5/9 = 0 r 5
    run_op(1'b1, 8'd100, 8'd7, 3'd5, lat, nbusy);
    check("div1_lat", 32'(lat), 32'd9);
    check("div1_lo",  32'(bus.lo), 32'h0E);
    check("div1_hi",  32'(bus.hi), 32'h02);
    check("div1_wa",  32'(bus.wa_o), 32'd5);
    check("div1_wd",  32'(bus.wd_o), 32'h0E);
    check_idle("div1");
    run_op(1'b1, 8'd5, 8'd9, 3'd2, lat, nbusy);
    check("div2_lo", 32'(bus.lo), 32'h00);
    check("div2_hi", 32'(bus.hi), 32'h05);
    check_idle("div2");

    // 4: divide by zero
    run_op(1'b1, 8'h37, 8'd0, 3'd4, lat, nbusy);
    check("dz_lat", 32'(lat), 32'd1);
    check("dz_lo",  32'(bus.lo), 32'hFF);
    check("dz_hi",  32'(bus.hi), 32'h37);
    check("dz_wd",  32'(bus.wd_o), 32'hFF);
    check("dz_rw",  32'(bus.regwrite_o), 32'd1);
    check_idle("dz");

    // 5: dest=0 suppresses regwrite; starts during CALC and WB are dropped
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 8'd3; bus.b = 8'd4; bus.dest = 3'd0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 2) begin
        bus.start = 1'b1; bus.op = 1'b0; bus.a = 8'd9; bus.b = 8'd9; bus.dest = 3'd7;
      end else if (i == 3) begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        ndone++;
        if (ndone == 1) begin
          check("d0_rw", 32'(bus.regwrite_o), 32'd0);
          check("d0_lo", 32'(bus.lo), 32'h0C);
          bus.start = 1'b1; bus.op = 1'b0; bus.a = 8'd9; bus.b = 8'd9; bus.dest = 3'd7;
          @(posedge clk);
          #1 bus.start = 1'b0;
        end
      end
    end
    check("d0_ndone", 32'(ndone), 32'd1);
    check("d0_busy",  32'(bus.busy), 32'd0);
    check("d0_lo_kept", 32'(bus.lo), 32'h0C);

    // 6: reset in the 4th CALC cycle aborts the op
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 8'd50; bus.b = 8'd3; bus.dest = 3'd2;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("ab_busy_pre", 32'(bus.busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("ab_busy", 32'(bus.busy), 32'd0);
    check("ab_done", 32'(bus.done), 32'd0);
    check("ab_rw",   32'(bus.regwrite_o), 32'd0);
    check("ab_hi",   32'(bus.hi), 32'd0);
    check("ab_lo",   32'(bus.lo), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op(1'b0, 8'd2, 8'd3, 3'd1, lat, nbusy);
    check("post_lat", 32'(lat), 32'd9);
    check("post_lo",  32'(bus.lo), 32'h06);
    check("post_hi",  32'(bus.hi), 32'h00);
    check_idle("post");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
